// File: rtl/fetch_issue.sv
// ---------------------------------------------------------------------------
// fetch_issue
//
// Instruction fetch/issue front end. It fetches one word at a time over a
// req/ack instruction-memory port and presents it on inst for exactly one
// ISSUE cycle. The decoder's control for that word (ctrl_a) selects the next
// step:
//   - a branch or jump waits FLUSH_SLOTS cycles (flush=1) until its control
//     reaches ctrl_c, and the PC is then steered there;
//   - a multiply holds the front end for MUL_CYCLES-1 cycles (stall=1);
//   - anything else fetches pc+1 straight away.
// Outside ISSUE inst is 16'h0000 (nop), so the decoder pipeline fills with
// bubbles.
//
// Ports
//   clk, rst_n      clock (posedge) and asynchronous active-low reset
//   ctrl_a          decoder control of the word currently on inst
//   ctrl_c          decoder control two stages back (branch/jump resolution)
//   ula_zero        ALU zero flag aligned with ctrl_c
//   branch_target   conditional branch target aligned with ctrl_c
//   jump_target     jump target aligned with ctrl_c
//   imem_req/addr   fetch request and address (address stable while req=1)
//   imem_ack/rdata  fetch completion and data, sampled only while req=1
//   inst            instruction to the decoder, nop except during ISSUE
//   pc              address of the last issued instruction
//   stall           high during multiply stall cycles
//   flush           high during branch/jump resolution cycles
// ---------------------------------------------------------------------------
module fetch_issue #(
    parameter int PC_W        = 12,
    parameter int INST_W      = 16,
    parameter int FLUSH_SLOTS = 2,
    parameter int MUL_CYCLES  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       ctrl_a,
    input  logic [15:0]       ctrl_c,
    input  logic              ula_zero,
    input  logic [PC_W-1:0]   branch_target,
    input  logic [PC_W-1:0]   jump_target,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc,
    output logic              stall,
    output logic              flush
);

    // One counter serves both the resolve window and the multiply stall, so
    // it is sized for whichever is longer.
    localparam int CNT_MAX = (FLUSH_SLOTS > MUL_CYCLES - 1) ? FLUSH_SLOTS : MUL_CYCLES - 1;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_FLUSH  = CNT_W'(FLUSH_SLOTS);
    localparam logic [CNT_W-1:0] CNT_MUL    = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_ONE     = PC_W'(1);
    localparam bit               MUL_STALLS = (MUL_CYCLES > 1);

    typedef enum logic [2:0] {
        BOOT,
        FETCH,
        ISSUE,
        RESOLVE,
        MUL
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   next_pc;
    logic [CNT_W-1:0]  cnt;

    logic [PC_W-1:0]   pc_inc;
    logic              is_xfer;
    logic              is_mul;
    logic [PC_W-1:0]   resolved_pc;

    // Sequential successor wraps modulo 2^PC_W with no carry out.
    assign pc_inc = pc + PC_ONE;

    // Any hint of a control transfer (branch flag or a non-zero FonteCP)
    // sends the front end into the resolve window; it outranks Mul.
    assign is_xfer = ctrl_a[0] | (ctrl_a[7:6] != 2'b00);
    assign is_mul  = ctrl_a[10];

    // Steering from the control that has reached ctrl_c: jump beats a taken
    // branch, and everything else (including FonteCP=11) falls through.
    always_comb begin
        resolved_pc = pc_inc;
        if (ctrl_c[7:6] == 2'b10) begin
            resolved_pc = jump_target;
        end else if ((ctrl_c[7:6] == 2'b01) && ctrl_c[0] && ula_zero) begin
            resolved_pc = branch_target;
        end
    end

    // Control bits that do not influence fetch steering.
    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl_a[15:11], ctrl_a[9:8], ctrl_a[5:1],
                           ctrl_c[15:8], ctrl_c[5:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            next_pc   <= '0;
            cnt       <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            inst      <= '0;
            pc        <= '0;
            stall     <= 1'b0;
            flush     <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    imem_req  <= 1'b1;
                    imem_addr <= next_pc;
                    state     <= FETCH;
                end

                FETCH: begin
                    // An ack in the very first FETCH cycle is accepted.
                    if (imem_req && imem_ack) begin
                        imem_req <= 1'b0;
                        inst     <= imem_rdata;
                        pc       <= imem_addr;
                        state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    inst <= '0;
                    if (is_xfer) begin
                        cnt   <= CNT_FLUSH;
                        flush <= 1'b1;
                        state <= RESOLVE;
                    end else if (is_mul && MUL_STALLS) begin
                        cnt   <= CNT_MUL;
                        stall <= 1'b1;
                        state <= MUL;
                    end else begin
                        next_pc   <= pc_inc;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_inc;
                        state     <= FETCH;
                    end
                end

                RESOLVE: begin
                    cnt <= cnt - CNT_ONE;
                    // In the final slot the transfer's own control is on
                    // ctrl_c, together with its flag and targets.
                    if (cnt == CNT_ONE) begin
                        flush     <= 1'b0;
                        next_pc   <= resolved_pc;
                        imem_req  <= 1'b1;
                        imem_addr <= resolved_pc;
                        state     <= FETCH;
                    end
                end

                MUL: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        stall     <= 1'b0;
                        next_pc   <= pc_inc;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_inc;
                        state     <= FETCH;
                    end
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_issue.sv
// ---------------------------------------------------------------------------
// tb_fetch_issue
//
// Bench for fetch_issue. A small program in a bench memory is executed.
// The decoder is stood in for by a word-to-control table plus a two-stage
// delay line that produces ctrl_c, ula_zero and the targets. The reference
// model works at instruction level: for each accepted fetch it derives the
// issued word, the bubble kind and count, and the next fetch address from
// the opcode. The outputs are then compared on every cycle. Issue order and
// bubble totals are also checked against hand-written literal lists.
//
// Opcodes (word[15:12]) used by the program; payload is word[11:0]:
//   1 normal    2 jump->payload         3 branch, zero=1 (taken)
//   B branch, zero=0 (not taken)        4 mul
//   5 ctrl[0] only (FonteCP=00)         6 jump + mul bit
//   7 FonteCP=11                        8 FonteCP=01 without branch flag
// ---------------------------------------------------------------------------
module tb_fetch_issue;

    localparam int PC_W        = 12;
    localparam int INST_W      = 16;
    localparam int FLUSH_SLOTS = 2;
    localparam int MUL_CYCLES  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       ctrl_a;
    logic [15:0]       ctrl_c;
    logic              ula_zero;
    logic [PC_W-1:0]   branch_target;
    logic [PC_W-1:0]   jump_target;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              stall;
    logic              flush;

    fetch_issue #(
        .PC_W        (PC_W),
        .INST_W      (INST_W),
        .FLUSH_SLOTS (FLUSH_SLOTS),
        .MUL_CYCLES  (MUL_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctrl_a        (ctrl_a),
        .ctrl_c        (ctrl_c),
        .ula_zero      (ula_zero),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst          (inst),
        .pc            (pc),
        .stall         (stall),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    // ---------------- decoder stand-in ----------------
    function automatic logic [15:0] dec_ctrl(input logic [15:0] w);
        logic [15:0] c;
        c = 16'h0000;
        case (w[15:12])
            4'h1:        c = 16'hF302;   // harmless bits only
            4'h2:        c = 16'h0080;
            4'h3, 4'hB:  c = 16'h0041;
            4'h4:        c = 16'h0400;
            4'h5:        c = 16'h0001;
            4'h6:        c = 16'h0480;
            4'h7:        c = 16'h00C0;
            4'h8:        c = 16'h0040;
            default:     c = 16'h0000;
        endcase
        return c;
    endfunction

    assign ctrl_a = dec_ctrl(inst);

    int cyc = 0;

    task automatic dec_attr(input logic [15:0] w, output logic z,
                            output logic [11:0] bt, output logic [11:0] jt);
        if (w == 16'h0000) begin
            z  = cyc[0];
            bt = 12'hABC;
            jt = 12'h5A5;
        end else begin
            z  = (w[15:12] != 4'hB);
            bt = w[11:0];
            jt = ~w[11:0];
            if (w[15:12] == 4'h2 || w[15:12] == 4'h6) begin
                bt = ~w[11:0];
                jt = w[11:0];
            end
        end
    endtask

    logic [15:0] c_s0 = '0, c_s1 = '0;
    logic        z_s0 = 1'b0, z_s1 = 1'b0;
    logic [11:0] b_s0 = '0, b_s1 = '0, j_s0 = '0, j_s1 = '0;

    // ---------------- program memory and ack timing ----------------
    logic [15:0] mem [0:4095];
    int          dly [0:4095];

    // ---------------- instruction-level reference model ----------------
    typedef struct packed {
        logic        req;
        logic [11:0] addr;
        logic [15:0] inst;
        logic [11:0] pc;
        logic        stall;
        logic        flush;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] m_addr = '0;
    logic [11:0] m_pc = '0;
    int          wait_cnt = 0;
    int          issued = 0;
    bit          in_reset = 1'b1;

    // Observations of the DUT, checked against literal lists per segment.
    int          dut_issue_q[$];
    int          flush_seen = 0;
    int          stall_seen = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
        end
    endtask

    task automatic model_issue();
        logic [15:0] w;
        logic [11:0] nxt;
        int          nb;
        bit          is_stall;
        w        = mem[m_addr];
        nxt      = m_addr + 12'd1;
        nb       = 0;
        is_stall = 1'b0;
        case (w[15:12])
            4'h2, 4'h6, 4'h3: begin nb = FLUSH_SLOTS; nxt = w[11:0]; end
            4'h5, 4'h7, 4'h8, 4'hB: nb = FLUSH_SLOTS;
            4'h4: begin nb = MUL_CYCLES - 1; is_stall = 1'b1; end
            default: nb = 0;
        endcase
        exp_q.push_back('{req: 1'b0, addr: 12'h000, inst: w, pc: m_addr, stall: 1'b0, flush: 1'b0});
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back('{req: 1'b0, addr: 12'h000, inst: 16'h0000, pc: m_addr,
                              stall: is_stall, flush: !is_stall});
        end
        m_pc   = m_addr;
        m_addr = nxt;
        issued++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_addr   = '0;
        m_pc     = '0;
        wait_cnt = 0;
        issued   = 0;
        in_reset = 1'b1;
        dut_issue_q.delete();
        flush_seen = 0;
        stall_seen = 0;
    endtask

    // One clock cycle: compare at the falling edge, then drive the inputs
    // that the next rising edge will sample.
    task automatic do_cycle();
        exp_t e;
        bit   fetch_cycle;
        @(negedge clk);
        cyc++;
        fetch_cycle = 1'b0;
        if (in_reset) begin
            e = '0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = '{req: 1'b1, addr: m_addr, inst: 16'h0000, pc: m_pc, stall: 1'b0, flush: 1'b0};
            fetch_cycle = 1'b1;
        end
        chk("imem_req", 32'(imem_req), 32'(e.req));
        if (e.req) chk("imem_addr", 32'(imem_addr), 32'(e.addr));
        chk("inst", 32'(inst), 32'(e.inst));
        chk("pc", 32'(pc), 32'(e.pc));
        chk("stall", 32'(stall), 32'(e.stall));
        chk("flush", 32'(flush), 32'(e.flush));

        if (inst != 16'h0000) begin
            dut_issue_q.push_back(int'(pc));
            $display("ISSUE cycle=%0d pc=%03h inst=%04h", cyc, pc, inst);
        end
        if (flush) flush_seen++;
        if (stall) stall_seen++;

        // decoder delay line: ctrl_c lags ctrl_a by two cycles
        ctrl_c        = c_s1;
        ula_zero      = z_s1;
        branch_target = b_s1;
        jump_target   = j_s1;
        c_s1 = c_s0; z_s1 = z_s0; b_s1 = b_s0; j_s1 = j_s0;
        c_s0 = dec_ctrl(inst);
        dec_attr(inst, z_s0, b_s0, j_s0);

        // memory: acks only where the model expects a fetch, plus junk
        // acks elsewhere that must be ignored
        if (in_reset) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'h7BAD;
        end else if (fetch_cycle) begin
            if (wait_cnt >= dly[m_addr]) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[m_addr];
                wait_cnt   = 0;
                model_issue();
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'hDEAD;
                wait_cnt++;
            end
        end else begin
            imem_ack   = (cyc % 3 == 0);
            imem_rdata = 16'h7BAD;
        end
    endtask

    task automatic run_until_issued(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (!(issued >= n && exp_q.size() == 0) && k < budget) begin
            do_cycle();
            k++;
        end
        chk({name, "_in_time"}, 32'(k < budget), 32'd1);
    endtask

    int seq_a[16] = '{'h000, 'h001, 'h002, 'h003, 'h004, 'h005, 'h040, 'h041,
                      'h042, 'h043, 'h008, 'h020, 'h021, 'hFFE, 'hFFF, 'h000};
    int seq_b[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

    initial begin
        int k;
        rst_n         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        ctrl_c        = '0;
        ula_zero      = 1'b0;
        branch_target = '0;
        jump_target   = '0;
        for (int a = 0; a < 4096; a++) begin
            mem[a] = 16'h1000 | 16'(a);
            dly[a] = 0;
        end

        // ---- segment A: boot, mul, jump, resolve variants, branches, wrap
        mem[12'h000] = 16'h1123;
        mem[12'h003] = 16'h4000;
        mem[12'h005] = 16'h2040;
        mem[12'h040] = 16'h5077;
        mem[12'h041] = 16'h7099;
        mem[12'h042] = 16'h8055;
        mem[12'h043] = 16'h6008;
        mem[12'h008] = 16'h3020;
        mem[12'h020] = 16'hB030;
        mem[12'h021] = 16'h2FFE;
        dly[12'h000] = 1;
        dly[12'h004] = 2;
        dly[12'h040] = 3;
        dly[12'hFFF] = 1;

        model_reset();
        for (int i = 0; i < 3; i++) do_cycle();
        rst_n    = 1'b1;
        in_reset = 1'b0;

        run_until_issued(16, 400, "seg_a");
        chk("seg_a_count", 32'(dut_issue_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < dut_issue_q.size()) chk("seg_a_pc_order", 32'(dut_issue_q[i]), 32'(seq_a[i]));
        end
        chk("seg_a_flush_cycles", 32'(flush_seen), 32'd16);
        chk("seg_a_stall_cycles", 32'(stall_seen), 32'd2);
        chk("seg_a_model_next", 32'(m_addr), 32'h001);

        // ---- segment B: reset mid-fetch, then a not-taken branch
        rst_n = 1'b0;
        model_reset();
        mem[12'h005] = 16'h1005;
        mem[12'h008] = 16'hB020;
        dly[12'h007] = 6;
        for (int i = 0; i < 2; i++) do_cycle();
        rst_n    = 1'b1;
        in_reset = 1'b0;

        k = 0;
        while (!(exp_q.size() == 0 && m_addr == 12'h007 && wait_cnt == 2) && k < 300) begin
            do_cycle();
            k++;
        end
        chk("seg_b_reach_fetch7", 32'(k < 300), 32'd1);
        chk("seg_b_req_before_rst", 32'(imem_req), 32'd1);
        chk("seg_b_addr_before_rst", 32'(imem_addr), 32'h007);

        // Assert reset in the middle of the cycle; outputs must clear at once.
        #2;
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h7BAD;
        #1;
        chk("rst_async_req", 32'(imem_req), 32'd0);
        chk("rst_async_pc", 32'(pc), 32'd0);
        chk("rst_async_inst", 32'(inst), 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) do_cycle();
        rst_n    = 1'b1;
        in_reset = 1'b0;

        run_until_issued(11, 400, "seg_b");
        chk("seg_b_count", 32'(dut_issue_q.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < dut_issue_q.size()) chk("seg_b_pc_order", 32'(dut_issue_q[i]), 32'(seq_b[i]));
        end
        chk("seg_b_flush_cycles", 32'(flush_seen), 32'd2);
        chk("seg_b_stall_cycles", 32'(stall_seen), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
